// File: rtl/uart_pkg.sv
// Shared io_uart definitions: register byte offsets, STATUS bit indices,
// the common TX/RX state encoding and the baud divisor type.
package uart_pkg;

    localparam int unsigned REG_DATA   = 0;
    localparam int unsigned REG_STATUS = 1;
    localparam int unsigned REG_DIV_LO = 2;
    localparam int unsigned REG_DIV_HI = 3;

    localparam int unsigned ST_RX_NONEMPTY = 0;
    localparam int unsigned ST_TX_FULL     = 1;
    localparam int unsigned ST_TX_BUSY     = 2;
    localparam int unsigned ST_FRAME_ERR   = 3;
    localparam int unsigned ST_OVERRUN     = 4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    typedef logic [15:0] uart_div_t;

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO used for the io_uart TX and RX byte queues.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/io_uart.sv
// io_uart: memory-mapped UART responder on the split even/odd byte-lane I/O bus.
// Build option: define UART_IRQ_EN to generate the registered interrupt output.
module io_uart
    import uart_pkg::*;
#(
    parameter logic [15:0] BASEADDR  = 16'h0010,
    parameter int unsigned FIFODEPTH = 4,
    parameter uart_div_t   DIVRESET  = 16'd433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] read_addr_even,
    input  logic [14:0] read_addr_odd,
    input  logic [14:0] write_addr_even,
    input  logic [14:0] write_addr_odd,
    input  logic        write_en_even,
    input  logic        write_en_odd,
    input  logic [7:0]  write_data_even,
    input  logic [7:0]  write_data_odd,
    output logic [7:0]  read_data_even,
    output logic [7:0]  read_data_odd,
    input  logic        rxd,
    output logic        txd,
    output logic        irq
);

    localparam logic [14:0] EVEN_LO = 15'((BASEADDR + REG_DATA) >> 1);
    localparam logic [14:0] EVEN_HI = 15'((BASEADDR + REG_DIV_LO) >> 1);
    localparam logic [14:0] ODD_LO  = 15'((BASEADDR + REG_STATUS) >> 1);
    localparam logic [14:0] ODD_HI  = 15'((BASEADDR + REG_DIV_HI) >> 1);

    uart_div_t   div;
    logic        wr_data, wr_div_lo, wr_status, wr_div_hi;
    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic        rx_push, rx_pop, rx_full, rx_empty, rx_ferr;
    logic [7:0]  tx_head, rx_head, status, rd_even_n, rd_odd_n;
    logic        frame_err, overrun;

    uart_state_t tx_state, tx_state_n, rx_state, rx_state_n;
    uart_div_t   tx_cnt, tx_cnt_n, rx_cnt, rx_cnt_n;
    logic [2:0]  tx_bit, tx_bit_n, rx_bit, rx_bit_n;
    logic [7:0]  tx_shift, tx_shift_n, rx_shift, rx_shift_n;
    logic        tx_tick, rx_tick, rx_s1, rx_s2, rx_s3;

    assign wr_data   = write_en_even && (write_addr_even == EVEN_LO);
    assign wr_div_lo = write_en_even && (write_addr_even == EVEN_HI);
    assign wr_status = write_en_odd  && (write_addr_odd  == ODD_LO);
    assign wr_div_hi = write_en_odd  && (write_addr_odd  == ODD_HI);
    assign tx_push   = wr_data;
    assign rx_pop    = wr_status && write_data_odd[ST_RX_NONEMPTY];

    uart_fifo #(.DEPTH(FIFODEPTH), .WIDTH(8)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .din(write_data_even),
        .full(tx_full), .empty(tx_empty), .head(tx_head)
    );

    uart_fifo #(.DEPTH(FIFODEPTH), .WIDTH(8)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .din(rx_shift),
        .full(rx_full), .empty(rx_empty), .head(rx_head)
    );

    always_comb begin
        status                 = '0;
        status[ST_RX_NONEMPTY] = !rx_empty;
        status[ST_TX_FULL]     = tx_full;
        status[ST_TX_BUSY]     = !tx_empty || (tx_state != IDLE);
        status[ST_FRAME_ERR]   = frame_err;
        status[ST_OVERRUN]     = overrun;
    end

    always_comb begin
        rd_even_n = '0;
        rd_odd_n  = '0;
        if (read_addr_even == EVEN_LO)      rd_even_n = rx_empty ? '0 : rx_head;
        else if (read_addr_even == EVEN_HI) rd_even_n = div[7:0];
        if (read_addr_odd == ODD_LO)        rd_odd_n  = status;
        else if (read_addr_odd == ODD_HI)   rd_odd_n  = div[15:8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data_even <= '0;
            read_data_odd  <= '0;
            div            <= DIVRESET;
        end else begin
            read_data_even <= rd_even_n;
            read_data_odd  <= rd_odd_n;
            if (wr_div_lo) div[7:0]  <= write_data_even;
            if (wr_div_hi) div[15:8] <= write_data_odd;
        end
    end

    // Bit counters reload from div at every bit boundary, so divisor writes apply there.
    assign tx_tick = (tx_cnt == '0);
    assign rx_tick = (rx_cnt == '0);

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_pop     = 1'b0;
        if (tx_state != IDLE && !tx_tick) tx_cnt_n = tx_cnt - 1'b1;
        case (tx_state)
            IDLE: if (!tx_empty) begin
                tx_pop = 1'b1; tx_shift_n = tx_head; tx_cnt_n = div; tx_state_n = START;
            end
            START: if (tx_tick) begin
                tx_cnt_n = div; tx_bit_n = '0; tx_state_n = DATA;
            end
            DATA: if (tx_tick) begin
                tx_cnt_n   = div;
                tx_shift_n = tx_shift >> 1;
                tx_bit_n   = tx_bit + 1'b1;
                if (tx_bit == 3'd7) tx_state_n = STOP;
            end
            STOP: if (tx_tick) begin
                if (!tx_empty) begin
                    tx_pop = 1'b1; tx_shift_n = tx_head; tx_cnt_n = div; tx_state_n = START;
                end else begin
                    tx_state_n = IDLE;
                end
            end
        endcase
    end

    assign txd = (tx_state == START) ? 1'b0 : (tx_state == DATA) ? tx_shift[0] : 1'b1;

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        rx_ferr    = 1'b0;
        if (rx_state != IDLE && !rx_tick) rx_cnt_n = rx_cnt - 1'b1;
        case (rx_state)
            IDLE: if (rx_s3 && !rx_s2) begin
                rx_cnt_n = div >> 1; rx_state_n = START;
            end
            START: if (rx_tick) begin
                if (rx_s2) begin
                    rx_state_n = IDLE;
                end else begin
                    rx_cnt_n = div; rx_bit_n = '0; rx_state_n = DATA;
                end
            end
            DATA: if (rx_tick) begin
                rx_cnt_n   = div;
                rx_shift_n = {rx_s2, rx_shift[7:1]};
                rx_bit_n   = rx_bit + 1'b1;
                if (rx_bit == 3'd7) rx_state_n = STOP;
            end
            STOP: if (rx_tick) begin
                rx_push    = rx_s2;
                rx_ferr    = !rx_s2;
                rx_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= IDLE;  tx_cnt <= '0;  tx_bit <= '0;  tx_shift <= '0;
            rx_state <= IDLE;  rx_cnt <= '0;  rx_bit <= '0;  rx_shift <= '0;
            rx_s1    <= 1'b1;  rx_s2  <= 1'b1; rx_s3 <= 1'b1;
        end else begin
            tx_state <= tx_state_n; tx_cnt <= tx_cnt_n; tx_bit <= tx_bit_n; tx_shift <= tx_shift_n;
            rx_state <= rx_state_n; rx_cnt <= rx_cnt_n; rx_bit <= rx_bit_n; rx_shift <= rx_shift_n;
            rx_s1    <= rxd;        rx_s2  <= rx_s1;    rx_s3  <= rx_s2;
        end
    end

    // A new error event wins over a same-cycle write-1-to-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (rx_ferr)                                         frame_err <= 1'b1;
            else if (wr_status && write_data_odd[ST_FRAME_ERR])  frame_err <= 1'b0;
            if (rx_push && rx_full && !rx_pop)                   overrun   <= 1'b1;
            else if (wr_status && write_data_odd[ST_OVERRUN])    overrun   <= 1'b0;
        end
    end

`ifdef UART_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) irq <= 1'b0;
        else       irq <= !rx_empty || frame_err || overrun;
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_io_uart.sv
// Self-checking bench for io_uart: bus-level register model, serial frame
// driver on rxd and a frame decoder on txd, with randomized bytes and divisors.
`timescale 1ns/1ps
module tb_io_uart;

    localparam logic [15:0] BASE  = 16'h0010;
    localparam int          DEPTH = 4;
    localparam logic [14:0] W0    = 15'(BASE >> 1);
`ifdef UART_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] read_addr_even = '0, read_addr_odd = '0;
    logic [14:0] write_addr_even = '0, write_addr_odd = '0;
    logic        write_en_even = 1'b0, write_en_odd = 1'b0;
    logic [7:0]  write_data_even = '0, write_data_odd = '0;
    logic [7:0]  read_data_even, read_data_odd;
    logic        rxd = 1'b1;
    logic        txd, irq;

    io_uart #(.BASEADDR(BASE), .FIFODEPTH(DEPTH), .DIVRESET(16'd433)) dut (
        .clk(clk), .reset(reset),
        .read_addr_even(read_addr_even), .read_addr_odd(read_addr_odd),
        .write_addr_even(write_addr_even), .write_addr_odd(write_addr_odd),
        .write_en_even(write_en_even), .write_en_odd(write_en_odd),
        .write_data_even(write_data_even), .write_data_odd(write_data_odd),
        .read_data_even(read_data_even), .read_data_odd(read_data_odd),
        .rxd(rxd), .txd(txd), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: RX queue and sticky flags, expected/observed TX bytes.
    logic [7:0] rx_q[$];
    bit         m_fe = 1'b0, m_ovr = 1'b0;
    logic [7:0] tx_exp[$], tx_got[$];
    int         tx_bad_stop = 0;
    int         cur_div = 433;
    int         mon_bt;
    logic [7:0] mon_b;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rd(input int off, output logic [7:0] v);
        read_addr_even = W0 + 15'(off / 2);
        read_addr_odd  = W0 + 15'(off / 2);
        @(negedge clk);
        v = (off % 2 == 0) ? read_data_even : read_data_odd;
    endtask

    task automatic wr(input int off, input logic [7:0] d);
        if (off % 2 == 0) begin
            write_addr_even = W0 + 15'(off / 2); write_data_even = d; write_en_even = 1'b1;
        end else begin
            write_addr_odd = W0 + 15'(off / 2); write_data_odd = d; write_en_odd = 1'b1;
        end
        @(negedge clk);
        write_en_even = 1'b0;
        write_en_odd  = 1'b0;
    endtask

    task automatic wr_both(input int word_off, input logic [7:0] de, input logic [7:0] dodd);
        write_addr_even = W0 + 15'(word_off); write_data_even = de;   write_en_even = 1'b1;
        write_addr_odd  = W0 + 15'(word_off); write_data_odd  = dodd; write_en_odd  = 1'b1;
        @(negedge clk);
        write_en_even = 1'b0;
        write_en_odd  = 1'b0;
    endtask

    task automatic set_div(input int d);
        wr_both(1, 8'(d), 8'(d >> 8));
        cur_div = d;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit good, input int gap_bits);
        int bt;
        logic [9:0] fr;
        bt = cur_div + 1;
        fr = {good, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = fr[i];
            repeat (bt) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (bt * gap_bits) @(negedge clk);
        if (!good)                    m_fe = 1'b1;
        else if (rx_q.size() < DEPTH) rx_q.push_back(b);
        else                          m_ovr = 1'b1;
    endtask

    task automatic check_status(input string tag, input logic [7:0] tx_bits);
        logic [7:0] v, e;
        rd(1, v);
        e = {3'b000, m_ovr, m_fe, 3'b000} | tx_bits | {7'd0, rx_q.size() != 0};
        check(tag, v, e);
        check({tag, "_irq"}, irq, IRQ_ON && (rx_q.size() != 0 || m_fe || m_ovr));
    endtask

    task automatic drain_rx(input string tag);
        logic [7:0] v;
        while (rx_q.size() != 0) begin
            rd(0, v);
            check({tag, "_data"}, v, rx_q.pop_front());
            wr(1, 8'h01);
        end
    endtask

    task automatic tx_verify(input string tag);
        int budget;
        budget = 5000;
        while (tx_got.size() < tx_exp.size() && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check({tag, "_done"}, budget != 0, 1);
        repeat (12 * (cur_div + 1)) @(negedge clk);
        check({tag, "_count"}, tx_got.size(), tx_exp.size());
        for (int i = 0; i < tx_exp.size() && i < tx_got.size(); i++)
            check({tag, "_byte"}, tx_got[i], tx_exp[i]);
        check({tag, "_stop"}, tx_bad_stop, 0);
        tx_got.delete();
        tx_exp.delete();
        tx_bad_stop = 0;
    endtask

    // Decodes txd frames by mid-bit sampling at the current bit time.
    initial begin : tx_monitor
        forever begin
            @(negedge clk);
            if (txd === 1'b0 && reset === 1'b0) begin
                mon_bt = cur_div + 1;
                repeat (mon_bt / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (mon_bt) @(negedge clk);
                    mon_b[i] = txd;
                end
                repeat (mon_bt) @(negedge clk);
                if (txd !== 1'b1) tx_bad_stop++;
                tx_got.push_back(mon_b);
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [7:0]  v, b;
        logic [39:0] wave, wexp;
        int          p, n;

        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1'b1);
        check("rst_irq", irq, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_status("rst_status", 8'h00);
        rd(2, v); check("rst_div_lo", v, 8'hB1);
        rd(3, v); check("rst_div_hi", v, 8'h01);
        rd(0, v); check("rst_data", v, 8'h00);

        // Single TX frame with exact bit timing.
        set_div(3);
        b = 8'hA5;
        wr(0, b);
        tx_exp.push_back(b);
        check("t1_pre_start", txd, 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            wave[i] = txd;
            p = i / 4;
            wexp[i] = (p == 0) ? 1'b0 : (p <= 8) ? b[p-1] : 1'b1;
        end
        check("t1_wave", wave, wexp);
        @(negedge clk);
        check("t1_idle", txd, 1'b1);
        check_status("t1_status", 8'h00);
        tx_verify("t1");

        // Single RX frame, read and pop.
        send_frame(8'h3C, 1'b1, 1);
        check_status("rx1_status", 8'h00);
        rd(0, v); check("rx1_data", v, rx_q.pop_front());
        wr(1, 8'h01);
        check_status("rx1_popped", 8'h00);

        // TX FIFO fill: one byte in the shifter plus DEPTH queued, sixth dropped.
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            wr(0, b);
            tx_exp.push_back(b);
        end
        rd(1, v); check("fill4_status", v, 8'h04);
        b = 8'($urandom);
        wr(0, b);
        tx_exp.push_back(b);
        wr(0, 8'($urandom));
        rd(1, v); check("fill6_status", v, 8'h06);
        tx_verify("fill");
        check_status("fill_after", 8'h00);

        // RX overrun with no pops, then clear overrun only.
        for (int i = 0; i < 5; i++) send_frame(8'($urandom), 1'b1, 1);
        check_status("ovr_status", 8'h00);
        wr(1, 8'h10);
        m_ovr = 1'b0;
        check_status("ovr_cleared", 8'h00);
        drain_rx("ovr");
        check_status("ovr_drained", 8'h00);

        // Bad stop bit, then a 1-clock glitch that must not start a frame.
        send_frame(8'($urandom), 1'b0, 1);
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (4 * (cur_div + 1)) @(negedge clk);
        check_status("ferr_status", 8'h00);
        wr(1, 8'h08);
        m_fe = 1'b0;
        check_status("ferr_cleared", 8'h00);

        // Same-cycle DATA write and STATUS pop on the two lanes.
        send_frame(8'($urandom), 1'b1, 1);
        b = 8'($urandom);
        wr_both(0, b, 8'h01);
        void'(rx_q.pop_front());
        tx_exp.push_back(b);
        check_status("lanes_status", 8'h04);
        tx_verify("lanes");

        // Randomized divisors, frame counts and stop-bit errors.
        for (int it = 0; it < 6; it++) begin
            set_div($urandom_range(2, 9));
            n = $urandom_range(1, 6);
            for (int f = 0; f < n; f++)
                send_frame(8'($urandom), $urandom_range(0, 5) != 0, $urandom_range(1, 2));
            check_status("rand_status", 8'h00);
            wr(1, 8'h18);
            m_fe  = 1'b0;
            m_ovr = 1'b0;
            drain_rx("rand");
            check_status("rand_empty", 8'h00);
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                wr(0, b);
                tx_exp.push_back(b);
            end
            tx_verify("rand_tx");
        end

        // Asynchronous reset in the middle of a TX frame.
        set_div(3);
        wr(0, 8'h5A);
        repeat (15) @(negedge clk);
        #2 reset = 1'b1;
        #1 check("mid_rst_txd", txd, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        rx_q.delete();
        m_fe = 1'b0;
        m_ovr = 1'b0;
        cur_div = 433;
        check("post_rst_txd", txd, 1'b1);
        check_status("post_rst_status", 8'h00);
        rd(2, v); check("post_rst_div_lo", v, 8'hB1);
        rd(3, v); check("post_rst_div_hi", v, 8'h01);
        rd(6, v); check("post_rst_unmapped", v, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_uart.md
Name: io_uart

Overview:
- Memory-mapped UART peripheral that acts as a responder on the SoC's split even/odd byte-lane data bus, alongside memory and the GPIO I/O system.
- Sits in the I/O region below MEMADDRBASE. The top level routes I/O-qualified write enables to it and ORs its read data into the I/O read mux.
- Provides a TX FIFO, an RX FIFO, a programmable baud divisor, sticky error flags and an optional interrupt.

Parameters:
- BASEADDR, 16'h0010: byte address of register 0; must be a multiple of 4.
- FIFODEPTH, 4: depth of each of the TX and RX FIFOs; power of 2, at least 2.
- DIVRESET, 16'd433: reset value of the baud divisor; each bit lasts DIV+1 clocks.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- read_addr_even  input  15  even-lane word address (byte address >> 1)
- read_addr_odd  input  15  odd-lane word address
- write_addr_even  input  15  even-lane write word address
- write_addr_odd  input  15  odd-lane write word address
- write_en_even  input  1  even-lane write strobe (already I/O-qualified)
- write_en_odd  input  1  odd-lane write strobe
- write_data_even  input  8  even-lane write byte
- write_data_odd  input  8  odd-lane write byte
- read_data_even  output  8  registered even-lane read data
- read_data_odd  output  8  registered odd-lane read data
- rxd  input  1  serial in, asynchronous to clk
- txd  output  1  serial out
- irq  output  1  interrupt request

Behaviour:
- Register map (byte offsets):
  - 0 DATA: even lane, word BASEADDR/2.
  - 1 STATUS: odd lane, word BASEADDR/2.
  - 2 DIV_LO: even lane, word BASEADDR/2+1.
  - 3 DIV_HI: odd lane, word BASEADDR/2+1.
- Reads are side-effect free, because the CPU drives read addresses every cycle.
  - read_data_* is registered, giving 1-cycle latency, the same as memory.
  - A non-matching address returns 8'h00.
  - Read DATA returns the RX FIFO head, or 0 if the FIFO is empty.
- Write DATA: push to the TX FIFO. If the FIFO is full, the write is dropped silently.
- STATUS read bits: [0] rx_nonempty, [1] tx_full, [2] tx_busy (FIFO non-empty or shifter active), [3] frame_err (sticky), [4] overrun (sticky), [7:5] = 0.
- STATUS write: bit0=1 pops RX; bit3=1 and bit4=1 clear their flags (write-1-to-clear). All other bits are ignored.
- DIV_LO/DIV_HI are read/write. A new value takes effect at the next bit boundary.
- The two lanes are independent: same-cycle writes to DATA (even lane) and STATUS (odd lane) both take effect.
- Reset values: read_data_*=0, txd=1, irq=0, both FIFOs empty, flags=0, DIV=DIVRESET, both FSMs in IDLE.
  - Reset is asynchronous and may occur mid-frame; txd returns to 1 immediately.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: when the FIFO is non-empty, pop into the shifter and go to START. txd=0 for DIV+1 clocks.
  - DATA: 8 bits, LSB first.
  - STOP: txd=1 for DIV+1 clocks, then go back to START if the FIFO is non-empty, else IDLE.
  - The first start bit begins 1 clock after the DATA write.
- RX FSM (IDLE, START, DATA, STOP):
  - rxd passes through a 2-flop synchroniser.
  - IDLE: a falling edge goes to START.
  - START: sample at (DIV>>1)+1 clocks. If the sample is high, it was a glitch; return to IDLE.
  - DATA: 8 samples spaced DIV+1 apart.
  - STOP: sample; if 0, set frame_err, discard the byte and return to IDLE.
  - Otherwise push the byte. If the RX FIFO is full, set overrun and drop the new byte, unless a pop occurs in the same cycle, in which case the push is accepted.
- FIFOs: simultaneous push and pop is legal at any fill level. Pointers wrap modulo FIFODEPTH; a count of FIFODEPTH means full.

Optional Feature:
- Macro: UART_IRQ_EN.
- Defined: irq = registered (rx_nonempty | frame_err | overrun), updated 1 cycle after the condition and level-held until cleared.
- Not defined: irq is tied to 0 and no interrupt logic is generated.

Decomposition:
- Package uart_pkg holds:
  - register byte offsets;
  - STATUS bit indices;
  - typedef enum for the shared FSM states (IDLE, START, DATA, STOP);
  - 16-bit divisor typedef.
- One sub-module, uart_fifo, parameterised by depth and width 8 (push, pop, full, empty, head), instantiated for TX and RX.

Test Plan:
- Reset with DIV=3, write 8'hA5 to DATA -> txd goes low 1 clk later; txd bits 1,0,1,0,0,1,0,1, 4 clks each; stop bit; txd idles at 1 after 40 clks.
- Write DIV_LO=3, DIV_HI=0, then drive rxd with frame 8'h3C -> STATUS=8'h01 and DATA reads 8'h3C one cycle after the address; write STATUS=8'h01 -> STATUS reads 8'h00.
- Write 6 bytes to DATA with FIFODEPTH=4 -> STATUS[1]=1 after 5 writes (1 in shifter); the 6th byte is dropped; exactly 5 frames appear on txd.
- Send 5 frames with no pops -> STATUS=8'h11; the first 4 bytes are intact; write STATUS=8'h10 -> overrun clears, rx_nonempty stays 1.
- Frame with stop bit 0, then a 1-clk low glitch on rxd -> frame_err=1, FIFO empty, the glitch is ignored; with UART_IRQ_EN, irq=1 until STATUS write 8'h08.
- Assert reset mid-TX-frame -> txd=1, STATUS=8'h00, DIV reads back as DIVRESET (16'd433), even-lane read of a non-UART address returns 8'h00.
